llkid_key_loader: RTL
=====================

Name: llkid_key_loader

Overview:
- Initiator side of the LLKI discrete key interface.
- Accepts load-key and clear-key commands from the LLKI protocol processor, streams 64-bit key words into a mock-TSS core's discrete key port, and waits for completion or acknowledgement.
- Returns a status response for every command.
- Sits between the LLKI protocol-processing logic and one mock-TSS wrapped core.

Parameters:
- MAX_KEY_WORDS, 8: largest legal key length in 64-bit words.
- TIMEOUT_CYCLES, 1024: number of consecutive target-stall cycles that aborts a command.

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  1  0 = load key, 1 = clear key
- cmd_num_words  in  8  key length for load (ignored for clear)
- key_word_valid  in  1  upstream key word offered
- key_word_data  in  64  upstream key word
- key_word_ready  out  1  upstream word consumed when valid && ready
- rsp_valid  out  1  response pending
- rsp_status  out  2  00 ok, 01 timeout, 10 bad length, 11 protocol error
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- llkid_key_data  out  64  key word to target
- llkid_key_valid  out  1  key word valid
- llkid_key_ready  in  1  target accepts word when valid && ready
- llkid_key_complete  in  1  target reports full key loaded (level)
- llkid_clear_key  out  1  clear request (level)
- llkid_clear_key_ack  in  1  target clear acknowledge

Behaviour:
- Reset values, applied on the clock edge while rst is high, including mid-command: cmd_ready=0, key_word_ready=0, rsp_valid=0, rsp_status=00, llkid_key_valid=0, llkid_key_data=0, llkid_clear_key=0, word counters and timeout counter=0, state IDLE. Outstanding words are discarded.
- The first cycle after reset deasserts is IDLE with cmd_ready=1.
- States: IDLE, LOAD, WAIT_COMPLETE, CLEAR_REQ, RESP.
- IDLE:
  - cmd_ready=1; all other outputs are inactive.
  - On command acceptance, the next state is selected as follows.
  - Clear → CLEAR_REQ.
  - Load with cmd_num_words==0 or >MAX_KEY_WORDS → RESP with status 10. The LLKI pins are untouched.
  - Load with llkid_key_complete already high (stale key) → RESP with status 11. The caller must clear first.
  - Otherwise latch num_words → LOAD.
- LOAD:
  - A single registered output stage drives llkid_key_data/llkid_key_valid.
  - key_word_ready = (fetched < num_words) && (!llkid_key_valid || llkid_key_ready). This allows back-to-back words at one word per cycle.
  - An upstream word accepted in cycle N appears on llkid_key_data/valid in cycle N+1.
  - llkid_key_valid and llkid_key_data hold stable until llkid_key_ready is sampled high.
  - The sent counter increments on each target acceptance. When sent reaches num_words, llkid_key_valid drops the next cycle → WAIT_COMPLETE.
  - If llkid_key_complete is seen high before the last word is accepted → RESP with status 11. Any unconsumed upstream words are left unconsumed.
- WAIT_COMPLETE: when llkid_key_complete is high → RESP with status 00.
- CLEAR_REQ:
  - llkid_clear_key is held high from the cycle after acceptance until llkid_clear_key_ack is sampled high.
  - On ack → RESP with status 00; llkid_clear_key is low in RESP.
- Timeout:
  - The counter clears on entry to LOAD, WAIT_COMPLETE and CLEAR_REQ, and on every target word acceptance.
  - It increments in each cycle of target stall: (LOAD with llkid_key_valid && !llkid_key_ready), WAIT_COMPLETE with complete low, or CLEAR_REQ with ack low.
  - Upstream starvation (waiting on key_word_valid) does not count.
  - After TIMEOUT_CYCLES consecutive stall cycles → RESP with status 01. llkid_key_valid and llkid_clear_key are low in RESP.
- RESP:
  - rsp_valid=1 with rsp_status stable until rsp_ready is sampled high, then → IDLE.
  - cmd_ready=0 throughout. Exactly one response is issued per command.
- Simultaneous events:
  - Complete and timeout in the same cycle: complete wins (status 00).
  - Ack and timeout in the same cycle: ack wins.
  - Word acceptance in the same cycle as the timeout threshold clears the counter; no timeout is raised.
- A new command cannot be accepted in the same cycle as the response handshake; acceptance is one cycle later, in IDLE.

Test Plan:
- Load 4 words 0x1111..., 0x2222..., 0x3333..., 0x4444...; upstream and target always ready → words appear on consecutive cycles in order; complete is raised 2 cycles after the last word → rsp status 00; cmd_ready returns 1 cycle after rsp_ready.
- Load 3 words; target drops llkid_key_ready for 5 cycles on word 2 → llkid_key_data holds word 2 stable; no duplicate or lost words; status 00.
- Load 2 words with TIMEOUT_CYCLES=16; target never asserts ready → rsp status 01 after exactly 16 stall cycles; llkid_key_valid is low on the rsp cycle.
- Load with cmd_num_words=0, then with 9 → status 10 both times; llkid_key_valid is never asserted.
- Clear command; ack returned 3 cycles later → llkid_clear_key is high exactly 3 cycles, status 00. A subsequent load is attempted while complete is still high → status 11.
- Assert rst mid-LOAD after 2 of 4 words → all outputs are at reset values the next cycle; a fresh 1-word load then completes with status 00.

Source files
------------

// File: rtl/llkid_key_loader.sv
// LLKI discrete key interface initiator: streams key words into a mock-TSS core,
// requests key clears, and returns one status response per command.
//
//   state          | meaning
//   IDLE           | ready for a command
//   LOAD           | fetching upstream words and presenting them to the target
//   WAIT_COMPLETE  | all words sent, waiting for llkid_key_complete
//   CLEAR_REQ      | llkid_clear_key held high until acknowledged
//   RESP           | status response held until rsp_ready
module llkid_key_loader #(
  parameter int MAX_KEY_WORDS  = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [7:0]  cmd_num_words,
  input  logic        key_word_valid,
  input  logic [63:0] key_word_data,
  output logic        key_word_ready,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status,
  input  logic        rsp_ready,
  output logic [63:0] llkid_key_data,
  output logic        llkid_key_valid,
  input  logic        llkid_key_ready,
  input  logic        llkid_key_complete,
  output logic        llkid_clear_key,
  input  logic        llkid_clear_key_ack
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CLEAR = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_BAD_LEN = 2'b10;
  localparam logic [1:0] ST_PROTO   = 2'b11;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state;
  logic [7:0]    num_words;
  logic [7:0]    fetched;
  logic [7:0]    sent;
  logic [TW-1:0] tmo_cnt;

  logic up_acc;
  logic tgt_acc;
  logic last_acc;
  logic stall;
  logic tmo_hit;
  logic bad_len;

  assign cmd_ready      = (state == S_IDLE) && !rst;
  assign rsp_valid      = (state == S_RESP);
  assign key_word_ready = (state == S_LOAD) && (fetched < num_words) &&
                          (!llkid_key_valid || llkid_key_ready);

  assign up_acc   = key_word_valid && key_word_ready;
  assign tgt_acc  = (state == S_LOAD) && llkid_key_valid && llkid_key_ready;
  assign last_acc = tgt_acc && ((sent + 8'd1) == num_words);
  assign bad_len  = (cmd_num_words == 8'd0) || (cmd_num_words > 8'(MAX_KEY_WORDS));

  // Only target-side stalls count; upstream starvation never times out.
  always_comb begin
    stall = 1'b0;
    case (state)
      S_LOAD:  stall = llkid_key_valid && !llkid_key_ready;
      S_WAIT:  stall = !llkid_key_complete;
      S_CLEAR: stall = !llkid_clear_key_ack;
      default: stall = 1'b0;
    endcase
  end

  assign tmo_hit = stall && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      num_words       <= 8'd0;
      fetched         <= 8'd0;
      sent            <= 8'd0;
      tmo_cnt         <= '0;
      rsp_status      <= ST_OK;
      llkid_key_data  <= 64'd0;
      llkid_key_valid <= 1'b0;
      llkid_clear_key <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            fetched <= 8'd0;
            sent    <= 8'd0;
            tmo_cnt <= '0;
            if (cmd_op) begin
              llkid_clear_key <= 1'b1;
              state           <= S_CLEAR;
            end else if (bad_len) begin
              rsp_status <= ST_BAD_LEN;
              state      <= S_RESP;
            end else if (llkid_key_complete) begin
              rsp_status <= ST_PROTO;
              state      <= S_RESP;
            end else begin
              num_words <= cmd_num_words;
              state     <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (up_acc) begin
            llkid_key_data  <= key_word_data;
            llkid_key_valid <= 1'b1;
            fetched         <= fetched + 8'd1;
          end else if (tgt_acc) begin
            llkid_key_valid <= 1'b0;
          end

          if (tgt_acc) begin
            sent    <= sent + 8'd1;
            tmo_cnt <= '0;
          end else if (stall) begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end

          // Last acceptance beats a simultaneous complete; a word accepted on the
          // threshold cycle is not a stall, so it can never time out.
          if (last_acc) begin
            llkid_key_valid <= 1'b0;
            tmo_cnt         <= '0;
            state           <= S_WAIT;
          end else if (llkid_key_complete) begin
            llkid_key_valid <= 1'b0;
            rsp_status      <= ST_PROTO;
            state           <= S_RESP;
          end else if (tmo_hit) begin
            llkid_key_valid <= 1'b0;
            rsp_status      <= ST_TIMEOUT;
            state           <= S_RESP;
          end
        end

        S_WAIT: begin
          if (llkid_key_complete) begin
            rsp_status <= ST_OK;
            state      <= S_RESP;
          end else if (tmo_hit) begin
            rsp_status <= ST_TIMEOUT;
            state      <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        S_CLEAR: begin
          if (llkid_clear_key_ack) begin
            llkid_clear_key <= 1'b0;
            rsp_status      <= ST_OK;
            state           <= S_RESP;
          end else if (tmo_hit) begin
            llkid_clear_key <= 1'b0;
            rsp_status      <= ST_TIMEOUT;
            state           <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_status <= ST_OK;
            state      <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
